mem_io_responder: RTL

- Responder at the far end of the CPU byte memory bus: services `mem_a`/`mem_dout`/`mem_wr` requests and returns read data on `mem_din`.
- Holds a byte-wide RAM and the memory-mapped I/O at 0x30000/0x30004: UART TX FIFO, RX byte pull, cycle counter, and the program-stop flag.
- Drives `io_buffer_full` back to the CPU.
- Sits beside the CPU top in the system top and connects to the UART link layer.

---
 rtl/mem_io_responder.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_io_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_io_responder
// Description : Far-end responder for the CPU byte memory bus. Holds a
//               byte-wide RAM and the memory-mapped I/O block at
//               0x30000/0x30004 (UART TX FIFO, RX byte pull, cycle counter
//               snapshot, program-stop flag). Drives io_buffer_full back to
//               the CPU and talks to the UART link layer.
//               Optional macro CYCLE_CNT_EN enables the 32-bit cycle counter
//               and its read snapshot; without it counter reads return 0x00.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_io_responder #(
    parameter int RAM_ADDR_W    = 17,
    parameter int TX_FIFO_DEPTH = 16,
    parameter int FULL_MARGIN   = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        program_done,
    output logic        tx_overflow
);

    localparam int                c_PTR_W      = $clog2(TX_FIFO_DEPTH);
    localparam logic [c_PTR_W:0]  c_DEPTH      = (c_PTR_W + 1)'(TX_FIFO_DEPTH);
    localparam logic [c_PTR_W:0]  c_FULL_LEVEL = (c_PTR_W + 1)'(TX_FIFO_DEPTH - FULL_MARGIN);
    localparam logic [c_PTR_W:0]  c_ONE        = (c_PTR_W + 1)'(1);

    // Storage
    logic [7:0]           r_ram    [2**RAM_ADDR_W];
    logic [7:0]           r_tx_mem [TX_FIFO_DEPTH];

    // FIFO pointers carry one extra wrap bit so full and empty differ
    logic [c_PTR_W:0]     r_tx_wr_ptr;
    logic [c_PTR_W:0]     r_tx_rd_ptr;
    logic                 r_buf_full;
    logic                 r_program_done;
    logic                 r_tx_overflow;
    logic [7:0]           r_mem_din;

    // Request decode
    logic                 w_is_io;
    logic                 w_io_hi;
    logic [RAM_ADDR_W-1:0] w_ram_idx;
    logic                 w_ram_wr;
    logic                 w_rd_req;
    logic                 w_tx_push_req;
    logic [7:0]           w_tx_push_byte;
    logic                 w_rx_pop;
    logic [7:0]           w_rd_byte;

    // FIFO status
    logic [c_PTR_W:0]     w_tx_count;
    logic [c_PTR_W:0]     w_tx_count_next;
    logic                 w_tx_empty;
    logic                 w_tx_full;
    logic                 w_tx_pop;
    logic                 w_push_ok;
    logic                 w_push_drop;

    // Address bits outside the decoded window are deliberately ignored
    logic                 w_unused_bits;
    assign w_unused_bits = ^mem_a[31:18];

`ifdef CYCLE_CNT_EN
    logic [31:0]          r_cycle_cnt;
    logic [31:0]          r_snapshot;
`endif

    assign w_is_io        = (mem_a[17:16] == 2'b11);
    assign w_io_hi        = mem_a[2];
    assign w_ram_idx      = mem_a[RAM_ADDR_W-1:0];
    assign w_ram_wr       = rdy_in && !w_is_io && mem_wr;
    assign w_rd_req       = rdy_in && !mem_wr;

    // The stop port always queues 0x00; the data port drops NUL bytes
    assign w_tx_push_req  = rdy_in && w_is_io && mem_wr && (w_io_hi || (mem_dout != 8'h00));
    assign w_tx_push_byte = w_io_hi ? 8'h00 : mem_dout;

    assign w_rx_pop       = rdy_in && w_is_io && !mem_wr && !w_io_hi && rx_valid;

    assign w_tx_count     = r_tx_wr_ptr - r_tx_rd_ptr;
    assign w_tx_empty     = (w_tx_count == '0);
    assign w_tx_full      = (w_tx_count == c_DEPTH);
    assign w_tx_pop       = !w_tx_empty && tx_ready;

    // A pop in the same cycle frees the slot the push needs
    assign w_push_ok      = w_tx_push_req && (!w_tx_full || w_tx_pop);
    assign w_push_drop    = w_tx_push_req && w_tx_full && !w_tx_pop;

    assign w_tx_count_next = w_tx_count
                           + (w_push_ok ? c_ONE : '0)
                           - (w_tx_pop  ? c_ONE : '0);

    // Read data selection for the byte registered into mem_din
    always_comb begin
        w_rd_byte = 8'h00;
        if (!w_is_io) begin
            w_rd_byte = r_ram[w_ram_idx];
        end else if (!w_io_hi) begin
            w_rd_byte = rx_valid ? rx_data : 8'h00;
        end else begin
`ifdef CYCLE_CNT_EN
            // Byte 0 comes straight from the live counter, which is also
            // what the snapshot captures, keeping a 4-byte read coherent
            case (mem_a[1:0])
                2'd0:    w_rd_byte = r_cycle_cnt[7:0];
                2'd1:    w_rd_byte = r_snapshot[15:8];
                2'd2:    w_rd_byte = r_snapshot[23:16];
                default: w_rd_byte = r_snapshot[31:24];
            endcase
`else
            w_rd_byte = 8'h00;
`endif
        end
    end

    // RAM write port (contents intentionally survive reset)
    always_ff @(posedge clk_in) begin
        if (w_ram_wr) begin
            r_ram[w_ram_idx] <= mem_dout;
        end
    end

    // TX FIFO storage
    always_ff @(posedge clk_in) begin
        if (w_push_ok) begin
            r_tx_mem[r_tx_wr_ptr[c_PTR_W-1:0]] <= w_tx_push_byte;
        end
    end

    // FIFO pointers, almost-full flag and sticky status bits
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_tx_wr_ptr    <= '0;
            r_tx_rd_ptr    <= '0;
            r_buf_full     <= 1'b0;
            r_program_done <= 1'b0;
            r_tx_overflow  <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_tx_wr_ptr <= r_tx_wr_ptr + c_ONE;
            end
            if (w_tx_pop) begin
                r_tx_rd_ptr <= r_tx_rd_ptr + c_ONE;
            end
            r_buf_full <= (w_tx_count_next >= c_FULL_LEVEL);
            if (w_push_drop) begin
                r_tx_overflow <= 1'b1;
            end
            if (rdy_in && w_is_io && mem_wr && w_io_hi) begin
                r_program_done <= 1'b1;
            end
        end
    end

    // Read data register: updates only on accepted reads, holds otherwise
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_mem_din <= 8'h00;
        end else if (w_rd_req) begin
            r_mem_din <= w_rd_byte;
        end
    end

`ifdef CYCLE_CNT_EN
    // Free-running cycle counter and the snapshot loaded by a byte-0 read
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_cycle_cnt <= 32'h0;
            r_snapshot  <= 32'h0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 32'h1;
            if (w_rd_req && w_is_io && w_io_hi && (mem_a[1:0] == 2'd0)) begin
                r_snapshot <= r_cycle_cnt;
            end
        end
    end
`endif

    assign mem_din        = r_mem_din;
    assign io_buffer_full = r_buf_full;
    assign program_done   = r_program_done;
    assign tx_overflow    = r_tx_overflow;
    assign tx_valid       = !w_tx_empty;
    assign tx_data        = w_tx_empty ? 8'h00 : r_tx_mem[r_tx_rd_ptr[c_PTR_W-1:0]];
    assign rx_ready       = w_rx_pop && !rst_in;

endmodule
`default_nettype wire
